// File: rtl/video_pkg.sv
// Shared 640x480@60 timing constants and RGB565 -> RGB888 colour expansion.
package video_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned CNT_W    = 10;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Replicate the top bits into the low bits so full-scale maps to 8'hFF.
    function automatic rgb888_t rgb565_to_888(input logic [15:0] c);
        rgb888_t o;
        o.r = {c[15:11], c[15:13]};
        o.g = {c[10:5],  c[10:9]};
        o.b = {c[4:0],   c[4:2]};
        return o;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Free-running 800x525 raster counters with sync and active-video decode.
module vga_timing
    import video_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             hs_c,
    output logic             vs_c,
    output logic             de_c
);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_S = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_E = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_S = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_E = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + CNT_W'(1);
        end else begin
            hcnt <= hcnt + CNT_W'(1);
        end
    end

    assign hs_c = (hcnt >= H_SYNC_S) && (hcnt < H_SYNC_E);
    assign vs_c = (vcnt >= V_SYNC_S) && (vcnt < V_SYNC_E);
    assign de_c = (hcnt < H_ACT) && (vcnt < V_ACT);

endmodule

// File: rtl/fb_scanout.sv
// VRAM port-B scanout: 2x2 pixel-doubled framebuffer window over a border colour.
module fb_scanout
    import video_pkg::*;
#(
    parameter int unsigned FB_W   = 320,
    parameter int unsigned FB_H   = 200,
    parameter int unsigned H_OFF  = 0,
    parameter int unsigned V_OFF  = 40,
    parameter int unsigned ADDR_W = 17
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic [ADDR_W-1:0] vga_addr,
    input  logic [15:0]       vga_data,
    input  logic [15:0]       border_color,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_de,
    output logic              frame_start
);

    // One extra bit so counts left of the window wrap to values above its width.
    localparam int unsigned       REL_W     = CNT_W + 1;
    localparam logic [REL_W-1:0]  WIN_W     = REL_W'(2 * FB_W);
    localparam logic [REL_W-1:0]  WIN_H     = REL_W'(2 * FB_H);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(FB_W);

    logic [CNT_W-1:0]  hcnt;
    logic [CNT_W-1:0]  vcnt;
    logic              hs_c;
    logic              vs_c;
    logic              de_c;
    logic [REL_W-1:0]  hrel_c;
    logic [REL_W-1:0]  vrel_c;
    logic              win_h_c;
    logic              win_v_c;
    logic              in_win_c;
    logic              last_line_c;
    logic              line_end_c;
    logic              frame0_c;
    logic [ADDR_W-1:0] fx;
    logic [ADDR_W-1:0] line_base;
    logic              hs_q1;
    logic              vs_q1;
    logic              de_q1;
    logic              win_q1;
    logic              fs_q1;
    rgb888_t           col_c;

    vga_timing u_timing (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .hcnt  (hcnt),
        .vcnt  (vcnt),
        .hs_c  (hs_c),
        .vs_c  (vs_c),
        .de_c  (de_c)
    );

    // S0: window decode relative to the window origin
    assign hrel_c      = REL_W'(hcnt) - REL_W'(H_OFF);
    assign vrel_c      = REL_W'(vcnt) - REL_W'(V_OFF);
    assign win_h_c     = hrel_c < WIN_W;
    assign win_v_c     = vrel_c < WIN_H;
    assign in_win_c    = win_h_c && win_v_c;
    assign last_line_c = vrel_c == (WIN_H - REL_W'(1));
    assign line_end_c  = hcnt == CNT_W'(H_TOTAL - 1);
    assign frame0_c    = (hcnt == '0) && (vcnt == '0);

    // Column index advances after the second copy of each doubled pixel.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            fx <= '0;
        else if (!win_h_c)
            fx <= '0;
        else if (hrel_c[0])
            fx <= fx + ADDR_W'(1);
    end

    // Row base steps once per doubled line pair; frozen on the final line so it never reaches FB_W*FB_H.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            line_base <= '0;
        else if (vcnt == '0)
            line_base <= '0;
        else if (line_end_c && win_v_c && vrel_c[0] && !last_line_c)
            line_base <= line_base + LINE_STEP;
    end

    assign vga_addr = in_win_c ? (line_base + fx) : line_base;

    // S1: align control with the VRAM read data
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hs_q1  <= 1'b0;
            vs_q1  <= 1'b0;
            de_q1  <= 1'b0;
            win_q1 <= 1'b0;
            fs_q1  <= 1'b0;
        end else begin
            hs_q1  <= hs_c;
            vs_q1  <= vs_c;
            de_q1  <= de_c;
            win_q1 <= in_win_c;
            fs_q1  <= frame0_c;
        end
    end

    always_comb begin
        col_c = '0;
        if (de_q1)
            col_c = win_q1 ? rgb565_to_888(vga_data) : rgb565_to_888(border_color);
    end

    // S2: registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= 1'b0;
            vga_vs      <= 1'b0;
            vga_de      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vga_r       <= col_c.r;
            vga_g       <= col_c.g;
            vga_b       <= col_c.b;
            vga_hs      <= hs_q1;
            vga_vs      <= vs_q1;
            vga_de      <= de_q1;
            frame_start <= fs_q1;
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout: default window plus a narrow, short window instance.
module tb_fb_scanout;

    logic        clk_i;
    logic        rst_i;
    logic [15:0] border_color;
    logic [15:0] vdata1;
    logic [15:0] vdata2;
    logic [16:0] a1;
    logic [16:0] a2;
    logic [7:0]  r1, g1, b1, r2, g2, b2;
    logic        hs1, vs1, de1, fs1, hs2, vs2, de2, fs2;
    int          vmode;

    int n_chk;
    int n_err;
    int fs_cnt;
    int hs_cnt;
    int vs_cnt;
    int de_cnt;
    int bad_addr;

    fb_scanout u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .vga_addr     (a1),
        .vga_data     (vdata1),
        .border_color (border_color),
        .vga_r        (r1),
        .vga_g        (g1),
        .vga_b        (b1),
        .vga_hs       (hs1),
        .vga_vs       (vs1),
        .vga_de       (de1),
        .frame_start  (fs1)
    );

    fb_scanout #(.FB_W(160), .FB_H(4), .H_OFF(160), .V_OFF(2), .ADDR_W(17)) u_dut2 (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .vga_addr     (a2),
        .vga_data     (vdata2),
        .border_color (border_color),
        .vga_r        (r2),
        .vga_g        (g2),
        .vga_b        (b2),
        .vga_hs       (hs2),
        .vga_vs       (vs2),
        .vga_de       (de2),
        .frame_start  (fs2)
    );

    initial clk_i = 1'b0;
    always #20 clk_i = ~clk_i;

    // Synchronous-read VRAM models: data is the address unless a solid test colour is selected.
    always @(posedge clk_i) begin
        case (vmode)
            1:       vdata1 <= 16'hF800;
            2:       vdata1 <= 16'h07E0;
            3:       vdata1 <= 16'h8410;
            default: vdata1 <= a1[15:0];
        endcase
        vdata2 <= a2[15:0];
    end

    function automatic logic [15:0] pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic run_phase(input int ncyc, input bit post);
        int p;
        int oh;
        int ov;
        int cl;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk_i);
            cl    = (k / 800) % 525;
            vmode = 0;
            if (!post) begin
                if (cl == 43)      vmode = 1;
                else if (cl == 44) vmode = 2;
                else if (cl == 45) vmode = 3;
            end
            if (a1 >= 17'd64000) bad_addr++;
            if (a2 >= 17'd640)   bad_addr++;
            fs_cnt += int'(fs1);
            if (post && k == 1) begin
                chk("rst_fs_early", 32'(fs1), 32'd0);
                chk("rst_addr_restart", 32'(a1), 32'd0);
            end
            if (k == 2) chk(post ? "rst_fs_first" : "fs_first", 32'(fs1), 32'd1);
            p = k - 2;
            if (p >= 0) begin
                oh = p % 800;
                ov = (p / 800) % 525;
                if (ov == 1)  hs_cnt += int'(hs1);
                if (ov < 10)  de_cnt += int'(de1);
                vs_cnt += int'(vs1);
                if (!post) begin
                    if (ov == 0  && oh == 0)   chk("border_l0",   32'({r1, g1, b1}), 32'h0000FF);
                    if (ov == 0  && oh == 639) chk("de_c639",     32'(de1), 32'd1);
                    if (ov == 0  && oh == 640) chk("de_c640",     32'(de1), 32'd0);
                    if (ov == 0  && oh == 655) chk("hs_c655",     32'(hs1), 32'd0);
                    if (ov == 0  && oh == 656) chk("hs_c656",     32'(hs1), 32'd1);
                    if (ov == 0  && oh == 751) chk("hs_c751",     32'(hs1), 32'd1);
                    if (ov == 0  && oh == 752) chk("hs_c752",     32'(hs1), 32'd0);
                    if (ov == 39 && oh == 100) chk("border_l39",  32'({r1, g1, b1}), 32'h0000FF);
                    if (ov == 40 && oh == 0)   chk("l40_c0",      32'(pix(r1, g1, b1)), 32'd0);
                    if (ov == 40 && oh == 1)   chk("l40_c1",      32'(pix(r1, g1, b1)), 32'd0);
                    if (ov == 40 && oh == 2)   chk("l40_c2",      32'(pix(r1, g1, b1)), 32'd1);
                    if (ov == 40 && oh == 639) chk("l40_c639",    32'(pix(r1, g1, b1)), 32'd319);
                    if (ov == 40 && oh == 700) chk("blank_rgb",   32'({r1, g1, b1}), 32'h000000);
                    if (ov == 41 && oh == 0)   chk("l41_c0",      32'(pix(r1, g1, b1)), 32'd0);
                    if (ov == 41 && oh == 5)   chk("l41_c5",      32'(pix(r1, g1, b1)), 32'd2);
                    if (ov == 42 && oh == 0)   chk("l42_c0",      32'(pix(r1, g1, b1)), 32'd320);
                    if (ov == 42 && oh == 639) chk("l42_c639",    32'(pix(r1, g1, b1)), 32'd639);
                    if (ov == 43 && oh == 320) chk("col_red",     32'({r1, g1, b1}), 32'hFF0000);
                    if (ov == 44 && oh == 320) chk("col_green",   32'({r1, g1, b1}), 32'h00FF00);
                    if (ov == 45 && oh == 320) chk("col_8410",    32'({r1, g1, b1}), 32'h848284);
                    if (ov == 2  && oh == 159) chk("w2_c159",     32'({r2, g2, b2}), 32'h0000FF);
                    if (ov == 2  && oh == 160) chk("w2_c160",     32'(pix(r2, g2, b2)), 32'd0);
                    if (ov == 2  && oh == 479) chk("w2_c479",     32'(pix(r2, g2, b2)), 32'd159);
                    if (ov == 2  && oh == 480) chk("w2_c480",     32'({r2, g2, b2}), 32'h0000FF);
                    if (ov == 4  && oh == 160) chk("w2_l4_c160",  32'(pix(r2, g2, b2)), 32'd160);
                    if (ov == 9  && oh == 479) chk("w2_last",     32'(pix(r2, g2, b2)), 32'd639);
                    if (ov == 10 && oh == 300) chk("w2_l10",      32'({r2, g2, b2}), 32'h0000FF);
                end else begin
                    if (ov == 2 && oh == 160) chk("rst_w2_c160", 32'(pix(r2, g2, b2)), 32'd0);
                    if (ov == 2 && oh == 162) chk("rst_w2_c162", 32'(pix(r2, g2, b2)), 32'd1);
                    if (ov == 4 && oh == 160) chk("rst_w2_l4",   32'(pix(r2, g2, b2)), 32'd160);
                    if (ov == 5 && oh == 479) chk("rst_w2_l5",   32'(pix(r2, g2, b2)), 32'd319);
                end
            end
        end
    endtask

    initial begin
        n_chk        = 0;
        n_err        = 0;
        fs_cnt       = 0;
        hs_cnt       = 0;
        vs_cnt       = 0;
        de_cnt       = 0;
        bad_addr     = 0;
        vmode        = 0;
        border_color = 16'h001F;
        rst_i        = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("reset_rgb",  32'({r1, g1, b1}), 32'd0);
        chk("reset_ctl",  32'({hs1, vs1, de1, fs1}), 32'd0);
        chk("reset_addr", 32'(a1), 32'd0);
        rst_i = 1'b0;

        // Run to counter position (300,46), inside the window.
        run_phase(37100, 1'b0);
        chk("fs_count",   32'(fs_cnt), 32'd1);
        chk("hs_per_line", 32'(hs_cnt), 32'd96);
        chk("de_10_lines", 32'(de_cnt), 32'd6400);
        chk("vs_quiet",   32'(vs_cnt), 32'd0);
        chk("addr_bound", 32'(bad_addr), 32'd0);

        rst_i = 1'b1;
        #1;
        chk("async_rgb",   32'({r1, g1, b1}), 32'd0);
        chk("async_ctl",   32'({hs1, vs1, de1, fs1}), 32'd0);
        chk("async_addr",  32'(a1), 32'd0);
        chk("async_rgb2",  32'({r2, g2, b2}), 32'd0);
        chk("async_addr2", 32'(a2), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i    = 1'b0;
        fs_cnt   = 0;
        bad_addr = 0;

        run_phase(4600, 1'b1);
        chk("rst_fs_count",   32'(fs_cnt), 32'd1);
        chk("rst_addr_bound", 32'(bad_addr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
